grid_scanner: RTL

//  Read-side engine for the 8x8 battleship cell memory. On request it walks all 64 cells

---
 rtl/battleship_pkg.sv | 45 ++++
 rtl/grid_scanner_if.sv | 28 ++
 rtl/grid_scanner.sv | 123 ++++++++++++
 3 files changed

// File: rtl/battleship_pkg.sv
// Shared battleship definitions: cell codes, grid geometry and the cell classifier
// used by both the cell-memory writer and the grid scanner.
package battleship_pkg;

    localparam int GRID_DIM   = 8;
    localparam int GRID_CELLS = GRID_DIM * GRID_DIM;
    localparam int ADDR_W     = 6;
    localparam int COUNT_W    = 7;

    typedef enum logic [3:0] {
        CELL_EMPTY        = 4'd0,
        CELL_PREVIEW      = 4'd1,
        CELL_SHIP         = 4'd2,
        CELL_SHIP_PREVIEW = 4'd3,
        CELL_INVALID      = 4'd4,
        CELL_HIT          = 4'd5,
        CELL_MISS         = 4'd6
    } cell_e;

    typedef struct packed {
        logic is_ship;
        logic is_hit;
        logic is_miss;
    } cell_class_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN
    } scan_state_e;

    // Codes 0, 1, 4 and 7-15 belong to no class.
    function automatic cell_class_t classify_cell(input logic [3:0] code);
        cell_class_t c;
        c = '0;
        case (code)
            CELL_SHIP, CELL_SHIP_PREVIEW: c.is_ship = 1'b1;
            CELL_HIT:                     c.is_hit  = 1'b1;
            CELL_MISS:                    c.is_miss = 1'b1;
            default:                      c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/grid_scanner_if.sv
// Request, memory read port and fleet-total bundle of the grid scanner.
interface grid_scanner_if;

    logic       start;
    logic [2:0] rd_x;
    logic [2:0] rd_y;
    logic [3:0] rd_data;
    logic       busy;
    logic       done;
    logic [6:0] ship_cells;
    logic [6:0] hit_cells;
    logic [6:0] miss_cells;
    logic       placement_full;
    logic       fleet_sunk;

    modport master (
        input  start, rd_data,
        output rd_x, rd_y, busy, done,
        output ship_cells, hit_cells, miss_cells, placement_full, fleet_sunk
    );

    modport slave (
        output start, rd_data,
        input  rd_x, rd_y, busy, done,
        input  ship_cells, hit_cells, miss_cells, placement_full, fleet_sunk
    );

endinterface

// File: rtl/grid_scanner.sv
// Walks all 64 cells of the battleship memory through its read port and publishes
// ship/hit/miss totals once per complete scan.
module grid_scanner
    import battleship_pkg::*;
#(
    parameter int RD_LATENCY       = 1,
    parameter int TOTAL_SHIP_CELLS = 9,
    parameter int AUTO_RESCAN      = 0
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    grid_scanner_if.master bus
);

    scan_state_e               state_q, state_d;
    logic [ADDR_W-1:0]         addr_q;
    logic [ADDR_W-1:0]         rx_cnt_q;
    logic [RD_LATENCY-1:0]     vld_q, vld_d;
    logic [COUNT_W-1:0]        acc_ship_q, acc_hit_q, acc_miss_q;
    logic [COUNT_W-1:0]        acc_ship_d, acc_hit_d, acc_miss_d;
    logic [COUNT_W-1:0]        ship_q, hit_q, miss_q;
    logic                      busy_q, done_q, full_q, sunk_q;
    logic                      accept, issue, rx_tail, last_rx;
    cell_class_t               cls;

    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        issue   = 1'b0;
        rx_tail = vld_q[RD_LATENCY-1];
        last_rx = rx_tail && (rx_cnt_q == ADDR_W'(GRID_CELLS - 1));
        case (state_q)
            ST_IDLE: begin
                if (bus.start || (AUTO_RESCAN != 0)) begin
                    state_d = ST_SCAN;
                    accept  = 1'b1;
                end
            end
            ST_SCAN: begin
                issue = 1'b1;
                if (addr_q == ADDR_W'(GRID_CELLS - 1)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (last_rx) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The tail of the valid shift register marks the cycle rd_data belongs to this scan.
    always_comb begin
        vld_d      = RD_LATENCY'({vld_q, issue});
        cls        = classify_cell(bus.rd_data);
        acc_ship_d = acc_ship_q + COUNT_W'(rx_tail & cls.is_ship);
        acc_hit_d  = acc_hit_q  + COUNT_W'(rx_tail & cls.is_hit);
        acc_miss_d = acc_miss_q + COUNT_W'(rx_tail & cls.is_miss);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_q     <= '0;
            rx_cnt_q   <= '0;
            vld_q      <= '0;
            acc_ship_q <= '0;
            acc_hit_q  <= '0;
            acc_miss_q <= '0;
            ship_q     <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            full_q     <= 1'b0;
            sunk_q     <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            done_q <= last_rx;
            if (accept) begin
                addr_q     <= '0;
                rx_cnt_q   <= '0;
                acc_ship_q <= '0;
                acc_hit_q  <= '0;
                acc_miss_q <= '0;
                busy_q     <= 1'b1;
            end else begin
                if (issue) addr_q <= addr_q + 1'b1;
                if (rx_tail) begin
                    rx_cnt_q   <= rx_cnt_q + 1'b1;
                    acc_ship_q <= acc_ship_d;
                    acc_hit_q  <= acc_hit_d;
                    acc_miss_q <= acc_miss_d;
                end
            end
            // Totals move only here, so a scan in flight never exposes partial counts.
            if (last_rx) begin
                ship_q <= acc_ship_d;
                hit_q  <= acc_hit_d;
                miss_q <= acc_miss_d;
                full_q <= (acc_ship_d == COUNT_W'(TOTAL_SHIP_CELLS));
                sunk_q <= (acc_ship_d == '0) && (acc_hit_d != '0);
                busy_q <= 1'b0;
            end
        end
    end

    // The address wraps to 0 after cell 63, so rd_x/rd_y rest at 0 outside SCAN.
    assign bus.rd_x           = addr_q[2:0];
    assign bus.rd_y           = addr_q[5:3];
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.ship_cells     = ship_q;
    assign bus.hit_cells      = hit_q;
    assign bus.miss_cells     = miss_q;
    assign bus.placement_full = full_q;
    assign bus.fleet_sunk     = sunk_q;

endmodule
